idct_8pt_serial: RTL and testbench

//  Inverse 8-point DCT for the EEG decompression path. Accepts one block of eight

---
 rtl/idct_pkg.sv | 47 ++++
 rtl/idct_cos_rom.sv | 29 ++
 rtl/idct_8pt_serial.sv | 191 +++++++++++++++++++
 tb/tb_idct_8pt_serial.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// Shared constants for the serial 8-point IDCT: datapath widths, FSM encoding,
// saturation bounds and the Q1.14 cosine table generator.
package idct_pkg;

  localparam int COEF_W   = 19;
  localparam int SAMP_W   = 8;
  localparam int ROM_W    = 16;
  localparam int ROM_FRAC = 14;
  localparam int IN_FRAC  = 0;
  localparam int ACC_W    = COEF_W + ROM_W + 3;
  localparam int FRAC     = ROM_FRAC + IN_FRAC;

  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Row k=0 carries a(0)=1/sqrt(8); rows k>0 carry a(k)=1/2, i.e. 2^13*cos(m*pi/16).
  localparam logic signed [ROM_W-1:0] DC_GAIN = 16'sd5793;
  localparam logic signed [ROM_W-1:0] COS_MAG [9] = '{
    16'sd8192, 16'sd8035, 16'sd7568, 16'sd6811, 16'sd5793,
    16'sd4551, 16'sd3135, 16'sd1598, 16'sd0
  };

  // Entry {k,n}: fold the angle (2n+1)k*pi/16 into the first quadrant and pick the sign.
  function automatic logic signed [ROM_W-1:0] cos_entry(input logic [5:0] addr);
    logic [2:0] k;
    logic [2:0] n;
    logic [6:0] p;
    logic [5:0] m;
    logic       neg;
    k = addr[5:3];
    n = addr[2:0];
    p = 7'({n, 1'b1}) * 7'(k);
    m = {1'b0, p[4:0]};
    if (m > 6'd16) m = 6'd32 - m;
    neg = (m > 6'd8);
    if (neg) m = 6'd16 - m;
    if (k == 3'd0) return DC_GAIN;
    return neg ? -COS_MAG[m[3:0]] : COS_MAG[m[3:0]];
  endfunction

endpackage

// File: rtl/idct_cos_rom.sv
// 64-entry cosine ROM addressed by {k,n}; one-cycle registered read with enable.
module idct_cos_rom
  import idct_pkg::*;
(
  input  logic                    clk,
  input  logic                    srst_i,
  input  logic                    en_i,
  input  logic [5:0]              addr_i,
  output logic signed [ROM_W-1:0] data_o
);

  logic signed [ROM_W-1:0] table_w [64];
  logic signed [ROM_W-1:0] data_q;

  for (genvar gi = 0; gi < 64; gi++) begin : g_table
    assign table_w[gi] = cos_entry(6'(gi));
  end

  always_ff @(posedge clk) begin
    if (srst_i) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= table_w[addr_i];
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/idct_8pt_serial.sv
// Serial 8-point inverse DCT: one MAC walks k=0..7 per output sample n, then the
// rounded, saturated sample is offered on a valid/ready stream in order n=0..7.
module idct_8pt_serial
  import idct_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] coef0,
  input  logic signed [COEF_W-1:0] coef1,
  input  logic signed [COEF_W-1:0] coef2,
  input  logic signed [COEF_W-1:0] coef3,
  input  logic signed [COEF_W-1:0] coef4,
  input  logic signed [COEF_W-1:0] coef5,
  input  logic signed [COEF_W-1:0] coef6,
  input  logic signed [COEF_W-1:0] coef7,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [SAMP_W-1:0] out_data,
  output logic [2:0]               out_idx,
  output logic                     out_last,
  output logic                     out_sat,
  output logic                     busy
);

  localparam logic signed [ACC_W-1:0]  HALF_A = ACC_W'(2 ** (FRAC - 1));
  localparam logic signed [ACC_W-1:0]  MAX_A  = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0]  MIN_A  = ACC_W'(SAT_MIN);
  localparam logic signed [SAMP_W-1:0] MAX_S  = SAMP_W'(SAT_MAX);
  localparam logic signed [SAMP_W-1:0] MIN_S  = SAMP_W'(SAT_MIN);

  state_t                    state_q, state_d;
  logic [2:0]                n_q, n_d;
  logic [3:0]                cnt_q, cnt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [COEF_W-1:0]  coef_in [8];
  logic signed [COEF_W-1:0]  coef_q  [8];
  logic                      in_ready_q, in_ready_d;
  logic                      busy_q, busy_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [SAMP_W-1:0]  out_data_q, out_data_d;
  logic [2:0]                out_idx_q, out_idx_d;
  logic                      out_last_q, out_last_d;
  logic                      out_sat_q, out_sat_d;

  logic                      accept;
  logic                      rom_en;
  logic [5:0]                rom_addr;
  logic signed [ROM_W-1:0]   rom_data;
  logic [2:0]                k_prev;
  logic signed [ACC_W-1:0]   coef_ext, rom_ext, prod, acc_base, mac_sum, rnd_sum, shifted;
  logic signed [SAMP_W-1:0]  samp_sat;
  logic                      samp_clamped;

  assign coef_in[0] = coef0;
  assign coef_in[1] = coef1;
  assign coef_in[2] = coef2;
  assign coef_in[3] = coef3;
  assign coef_in[4] = coef4;
  assign coef_in[5] = coef5;
  assign coef_in[6] = coef6;
  assign coef_in[7] = coef7;

  assign accept = in_valid & in_ready_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      coef_q <= coef_in;
    end
  end

  // MAC cycle c issues address k=c; the product for k=c-1 is formed with the ROM word read last cycle.
  assign rom_en   = (state_q == ST_MAC) && (cnt_q < 4'd8);
  assign rom_addr = {cnt_q[2:0], n_q};
  assign k_prev   = cnt_q[2:0] - 3'd1;

  idct_cos_rom u_rom (
    .clk    (clk),
    .srst_i (rst_n),
    .en_i   (rom_en),
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

  assign coef_ext = ACC_W'(coef_q[k_prev]);
  assign rom_ext  = ACC_W'(rom_data);
  assign prod     = coef_ext * rom_ext;
  assign acc_base = (cnt_q == 4'd1) ? '0 : acc_q;
  assign mac_sum  = acc_base + prod;
  assign rnd_sum  = mac_sum + HALF_A;
  assign shifted  = rnd_sum >>> FRAC;

  always_comb begin
    samp_sat     = shifted[SAMP_W-1:0];
    samp_clamped = 1'b0;
    if (shifted > MAX_A) begin
      samp_sat     = MAX_S;
      samp_clamped = 1'b1;
    end else if (shifted < MIN_A) begin
      samp_sat     = MIN_S;
      samp_clamped = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    out_last_d = out_last_q;
    out_sat_d  = out_sat_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          n_d     = 3'd0;
          cnt_d   = 4'd0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q != 4'd0) begin
          acc_d = mac_sum;
        end
        // Final product lands this cycle; capture the finished sample so it is frozen through OUT.
        if (cnt_q == 4'd8) begin
          out_data_d = samp_sat;
          out_sat_d  = samp_clamped;
          out_idx_d  = n_q;
          out_last_d = (n_q == 3'd7);
          state_d    = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          if (n_q == 3'd7) begin
            state_d = ST_IDLE;
          end else begin
            n_d     = n_q + 3'd1;
            cnt_d   = 4'd0;
            state_d = ST_MAC;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    out_valid_d = (state_d == ST_OUT);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= ST_IDLE;
      n_q         <= 3'd0;
      cnt_q       <= 4'd0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= 3'd0;
      out_last_q  <= 1'b0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_idct_8pt_serial.sv
// Directed bench for idct_8pt_serial: a floating-point reference fills a scoreboard
// on every accepted block and each emitted sample is checked against it.
module tb_idct_8pt_serial;

  typedef struct {
    logic signed [7:0] data;
    logic [2:0]        idx;
    logic              last;
    logic              sat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b1;
  logic signed [18:0] coef [8];
  logic              in_ready, out_valid, out_last, out_sat, busy;
  logic signed [7:0] out_data;
  logic [2:0]        out_idx;
  logic signed [7:0] blk [8];

  always #5 clk = ~clk;

  idct_8pt_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .coef0     (coef[0]),
    .coef1     (coef[1]),
    .coef2     (coef[2]),
    .coef3     (coef[3]),
    .coef4     (coef[4]),
    .coef5     (coef[5]),
    .coef6     (coef[6]),
    .coef7     (coef[7]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint rom_ref(int k, int n);
    real a;
    real v;
    a = (k == 0) ? 1.0 / $sqrt(8.0) : 0.5;
    v = 16384.0 * a * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0);
    return longint'($floor(v + 0.5));
  endfunction

  function automatic exp_t model(int n);
    exp_t   e;
    longint acc;
    longint r;
    acc = 0;
    for (int k = 0; k < 8; k++) acc += rom_ref(k, n) * longint'(coef[k]);
    r = (acc + 64'sd8192) >>> 14;
    e.sat = 1'b1;
    if (r > 127) e.data = 8'sd127;
    else if (r < -128) e.data = -8'sd128;
    else begin
      e.data = 8'(r);
      e.sat  = 1'b0;
    end
    e.idx  = 3'(n);
    e.last = (n == 7);
    return e;
  endfunction

  task automatic set_coef(input int k, input int val);
    for (int i = 0; i < 8; i++) coef[i] = '0;
    coef[k] = 19'(val);
  endtask

  task automatic push_block();
    for (int n = 0; n < 8; n++) exp_q.push_back(model(n));
  endtask

  task automatic pop_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("unexpected_sample", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk("out_data", out_data, e.data);
    chk("out_idx", out_idx, e.idx);
    chk("out_last", out_last, e.last);
    chk("out_sat", out_sat, e.sat);
    blk[out_idx] = out_data;
  endtask

  // Called at a negedge with coef already set; returns at the negedge after the accept edge.
  task automatic send(input int budget);
    int t;
    t = 0;
    in_valid = 1'b1;
    while (!in_ready && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    push_block();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n, input int stall_idx, input int abort_idx, input int budget);
    int got;
    int extra;
    bit stalled;
    got = 0;
    stalled = 1'b0;
    for (int t = 0; t < budget && got < n; t++) begin
      @(negedge clk);
      if (abort_idx >= 0 && out_valid && out_idx == 3'(abort_idx)) begin
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out_idx", out_idx, 0);
        exp_q.delete();
        rst_n = 1'b0;
        extra = 0;
        repeat (20) begin
          @(negedge clk);
          extra += int'(out_valid);
        end
        chk("abort_no_more_samples", extra, 0);
        chk("abort_in_ready_back", in_ready, 1);
        return;
      end
      if (stall_idx >= 0 && !stalled && out_valid && out_idx == 3'(stall_idx)) begin
        stalled = 1'b1;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_out_valid", out_valid, 1);
          chk("stall_out_idx", out_idx, stall_idx);
          chk("stall_out_data", out_data, (exp_q.size() > 0) ? exp_q[0].data : 8'sd0);
        end
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        pop_check();
        got++;
      end
    end
    chk("drain_count", got, n);
    chk("drain_queue_empty", exp_q.size(), 0);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      extra += int'(out_valid);
    end
    chk("no_extra_samples", extra, 0);
  endtask

  initial begin
    int   acc_t[$];
    int   first_valid;
    int   busy_cnt;
    int   rdy_cnt;
    int   got;
    int   gap;

    for (int i = 0; i < 8; i++) coef[i] = '0;

    // Reset state while reset is asserted.
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);

    // DC only: every sample is 64.
    set_coef(0, 181);
    send(50);
    drain(8, -1, -1, 200);
    for (int n = 0; n < 8; n++) chk("t1_dc_value", blk[n], 64);

    // First harmonic: odd antisymmetry about the block centre.
    set_coef(1, 128);
    send(50);
    drain(8, -1, -1, 200);
    chk("t2_x0", blk[0], 63);
    chk("t2_x7", blk[7], -63);
    for (int n = 0; n < 4; n++) chk("t2_antisym", blk[n], -blk[7 - n]);

    // Saturation in both directions.
    set_coef(0, 2000);
    send(50);
    drain(8, -1, -1, 200);
    set_coef(0, -2000);
    send(50);
    drain(8, -1, -1, 200);

    // Mixed block with a five-cycle sink stall on sample 3.
    coef[0] = 19'sd100;  coef[1] = -19'sd50; coef[2] = 19'sd30; coef[3] = 19'sd0;
    coef[4] = -19'sd20;  coef[5] = 19'sd10;  coef[6] = 19'sd5;  coef[7] = -19'sd3;
    send(50);
    drain(8, 3, -1, 300);

    // Back-to-back blocks with in_valid held high.
    set_coef(0, 181);
    coef[2] = 19'sd300;
    first_valid = -1;
    busy_cnt = 0;
    rdy_cnt = 0;
    got = 0;
    in_valid = 1'b1;
    for (int t = 0; t < 400; t++) begin
      if (out_valid && out_ready) begin
        pop_check();
        got++;
      end
      if (got == 16) break;
      if (acc_t.size() == 1 && out_valid && first_valid < 0) first_valid = t;
      if (in_valid && in_ready) begin
        acc_t.push_back(t);
        push_block();
      end else if (acc_t.size() == 1) begin
        busy_cnt += int'(busy);
        rdy_cnt  += int'(in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    gap = (acc_t.size() >= 2) ? acc_t[1] - acc_t[0] : -1;
    chk("t5_accepts", acc_t.size(), 2);
    // 80 busy cycles, then the accept happens in the next IDLE cycle.
    chk("t5_accept_gap", gap, 81);
    chk("t5_busy_cycles", busy_cnt, 80);
    chk("t5_ready_while_busy", rdy_cnt, 0);
    chk("t5_first_valid_latency", (acc_t.size() >= 1) ? first_valid - acc_t[0] : -1, 10);
    chk("t5_samples", got, 16);
    repeat (3) @(negedge clk);
    chk("t5_queue_empty", exp_q.size(), 0);

    // Reset while sample 4 is on offer, then a fresh DC block.
    set_coef(0, 181);
    send(50);
    drain(8, -1, 4, 200);
    for (int n = 0; n < 8; n++) blk[n] = '0;
    set_coef(0, 181);
    send(50);
    drain(8, -1, -1, 200);
    for (int n = 0; n < 8; n++) chk("t6_dc_value", blk[n], 64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
